// File: rtl/uart_echo_rx.sv
// rtl/uart_echo_rx.sv - 8N1 UART receiver with LED display and byte echo
//
// Receives 8N1 frames on uart_rx. The low six bits of the most recent good
// byte are shown on the active-low LEDs, and every good byte is sent back out
// on uart_tx.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   uart_rx  serial receive line, idles high
//   uart_tx  serial transmit line, idles high, registered
//   led      active-low LED drive, ~last_good_byte[5:0]
//   btn      asynchronous active-low reset (push button)
`timescale 1ns/1ps
module uart_echo_rx #(
  parameter int DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [5:0] led,
  input  logic       btn
);

  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);

  // ------------------------------------------------------------------
  // Input synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  // ------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // ------------------------------------------------------------------
  // Receive FSM
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  rx_state_t       rx_state;
  rx_state_t       rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [CW-1:0]   rx_cnt_next;
  logic [2:0]      rx_idx;
  logic [2:0]      rx_idx_next;
  logic [7:0]      rx_data;
  logic            rx_sample_bit;
  logic            rx_good;
  logic            rx_valid;

  always_comb begin
    rx_next       = rx_state;
    rx_cnt_next   = rx_cnt + CNT_ONE;
    rx_idx_next   = rx_idx;
    rx_sample_bit = 1'b0;
    rx_good       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_s) rx_next = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in to reject short glitches.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_next = '0;
          if (rx_s) begin
            rx_next = RX_IDLE;
          end else begin
            rx_next     = RX_DATA;
            rx_idx_next = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_sample_bit = 1'b1;
          rx_idx_next   = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next = '0;
          if (rx_s) begin
            rx_good = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_next = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        // Framing error: hold off until the line is idle again so the
        // low stop bit is not mistaken for a new start bit.
        rx_cnt_next = '0;
        if (rx_s) rx_next = RX_IDLE;
      end
      default: begin
        rx_next     = RX_IDLE;
        rx_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      led      <= 6'b111111;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_next;
      rx_idx   <= rx_idx_next;
      rx_valid <= rx_good;
      if (rx_sample_bit) rx_data[rx_idx] <= rx_s;
      if (rx_good)       led <= ~rx_data[5:0];
    end
  end

  // ------------------------------------------------------------------
  // Echo holding register: newest good byte wins if one is still pending.
  // ------------------------------------------------------------------
  logic [7:0] tx_buf;
  logic       pending;
  logic       tx_load;

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      tx_buf  <= 8'h00;
      pending <= 1'b0;
    end else begin
      if (rx_valid) begin
        tx_buf  <= rx_data;
        pending <= 1'b1;
      end else if (tx_load) begin
        pending <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmit FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t       tx_state;
  tx_state_t       tx_next;
  logic [CW-1:0]   tx_cnt;
  logic [CW-1:0]   tx_cnt_next;
  logic [2:0]      tx_idx;
  logic [2:0]      tx_idx_next;
  logic [7:0]      tx_shift;
  logic [7:0]      tx_shift_next;
  logic            tx_line_next;

  always_comb begin
    tx_next       = tx_state;
    tx_cnt_next   = tx_cnt + CNT_ONE;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    tx_load       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (pending) begin
          tx_load       = 1'b1;
          tx_shift_next = tx_buf;
          tx_next       = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next = '0;
          tx_idx_next = 3'd0;
          tx_next     = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift[7:1]};
          tx_idx_next   = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next = '0;
          tx_next     = TX_IDLE;
        end
      end
      default: begin
        tx_next     = TX_IDLE;
        tx_cnt_next = '0;
      end
    endcase

    // Line level is derived from the upcoming state so the registered
    // output changes on the same edge as the state.
    case (tx_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_shift_next[0];
      default:  tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_next;
      tx_idx   <= tx_idx_next;
      tx_shift <= tx_shift_next;
      uart_tx  <= tx_line_next;
    end
  end

endmodule

// File: tb/tb_uart_echo_rx.sv
// tb/tb_uart_echo_rx.sv - self-checking bench for uart_echo_rx
`timescale 1ns/1ps
module tb_uart_echo_rx;

  localparam int DF = 8;

  logic       clk = 1'b0;
  logic       uart_rx = 1'b1;
  logic       btn = 1'b0;
  logic       uart_tx;
  logic [5:0] led;

  int checks = 0;
  int failures = 0;

  // Reference model: expected echo order and expected LED pattern.
  logic [7:0] exp_q[$];
  logic [5:0] led_exp = 6'b111111;
  int         echo_cnt = 0;
  bit         mon_busy = 1'b0;

  uart_echo_rx #(.DELAY_FRAMES(DF)) dut (
    .clk     (clk),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .led     (led),
    .btn     (btn)
  );

  always #1 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (DF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  // A good frame must update the LEDs and be echoed once, in order.
  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
    led_exp = ~b[5:0];
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(12);
  endtask

  task automatic mon_wait(input int n, inout bit ok);
    repeat (n) begin
      @(negedge clk);
      if (!btn) ok = 1'b0;
    end
  endtask

  // Serial monitor on uart_tx: samples at bit centres, compares each
  // complete frame with the head of the expected echo queue.
  initial begin
    logic [7:0] mb;
    logic       mst;
    logic       msp;
    bit         mok;
    forever begin
      @(negedge clk);
      if (btn && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        mok = 1'b1;
        mon_wait(3, mok);
        mst = uart_tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(DF, mok);
          mb[i] = uart_tx;
        end
        mon_wait(DF, mok);
        msp = uart_tx;
        if (mok) begin
          echo_cnt++;
          check_eq("echo_start_bit", {31'd0, mst}, 32'd0);
          check_eq("echo_stop_bit", {31'd0, msp}, 32'd1);
          check_eq("echo_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) check_eq("echo_byte", {24'd0, mb}, {24'd0, exp_q.pop_front()});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int prev_echo;
    bit found;
    logic [7:0] rb;
    int kind;

    // Reset state
    idle(5);
    check_eq("reset_led", {26'd0, led}, {26'd0, 6'b111111});
    check_eq("reset_tx", {31'd0, uart_tx}, 32'd1);
    btn = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (led !== 6'b111111 || uart_tx !== 1'b1) bad++;
    end
    check_eq("idle_1000_stable", bad, 0);

    // Single byte 0x61: LEDs hold until the stop bit is sampled.
    uart_rx = 1'b1;
    idle(4);
    exp_q.push_back(8'h61);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(rb_bit(8'h61, i));
    check_eq("led_before_stop", {26'd0, led}, {26'd0, 6'b111111});
    drive_bit(1'b1);
    led_exp = ~6'h21;
    check_eq("led_0x61", {26'd0, led}, {26'd0, 6'b011110});
    idle(100);

    // Glitch: no LED change, no echo.
    prev_echo = echo_cnt;
    glitch();
    idle(100);
    check_eq("glitch_led", {26'd0, led}, {26'd0, led_exp});
    check_eq("glitch_no_echo", echo_cnt, prev_echo);

    // Framing error then a valid 0x05.
    prev_echo = echo_cnt;
    send_frame(8'h3F, 1'b0);
    idle(100);
    check_eq("frame_err_led", {26'd0, led}, {26'd0, led_exp});
    check_eq("frame_err_no_echo", echo_cnt, prev_echo);
    send_good(8'h05);
    check_eq("led_0x05", {26'd0, led}, {26'd0, 6'b111010});
    idle(100);

    // Back-to-back frames with no idle gap.
    send_good(8'h12);
    check_eq("led_0x12", {26'd0, led}, {26'd0, 6'b101101});
    send_good(8'h34);
    check_eq("led_0x34", {26'd0, led}, {26'd0, 6'b001011});
    idle(200);

    // Randomized mix of good frames, framing errors and glitches.
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      rb = 8'($urandom);
      if (kind == 0) glitch();
      else if (kind == 1) send_frame(rb, 1'b0);
      else send_good(rb);
      idle($urandom_range(4, 20));
      check_eq("rand_led", {26'd0, led}, {26'd0, led_exp});
    end
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) found = 1'b1;
    end
    check_eq("rand_drain", exp_q.size(), 0);
    idle(20);

    // Asynchronous reset during TX data bit 3.
    send_good(8'h61);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (uart_tx === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("tx_start_seen", {31'd0, found}, 32'd1);
    idle(DF + DF * 3 + DF / 2);
    #0.3 btn = 1'b0;
    #0.2;
    check_eq("async_rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("async_rst_led", {26'd0, led}, {26'd0, 6'b111111});
    idle(5);
    exp_q.delete();
    led_exp = 6'b111111;
    btn = 1'b1;
    idle(60);
    send_good(8'h61);
    check_eq("post_rst_led", {26'd0, led}, {26'd0, 6'b011110});
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) found = 1'b1;
    end
    check_eq("post_rst_echo_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule

// File: doc/uart_echo_rx.md
Name: uart_echo_rx

Overview:
- 8N1 UART block with a single clock domain.
- Receives bytes on uart_rx and shows the low 6 bits of the last good byte on active-low LEDs.
- Echoes every good byte back out on uart_tx.
- Top-level board block: clk comes from the board oscillator, btn is the active-low reset button, led drives active-low LEDs.

Parameters:
- DELAY_FRAMES, default 234, clock cycles per UART bit (27 MHz / 115200). Integer, valid range >= 4. Benches use 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- btn  input  1  reset; asynchronous assert, active-low (0 = reset).
- uart_rx  input  1  serial receive line; idles high.
- uart_tx  output  1  serial transmit line; idles high.
- led  output  6  LED drive, active-low: led = ~last_good_byte[5:0].
- Declaration order is fixed: clk, uart_rx, uart_tx, led, btn. Instances connect positionally.

Behaviour:
- Reset (btn=0, async) sets the following; all counters clear:
  - led = 6'b111111 (all off)
  - uart_tx = 1
  - RX and TX FSMs = IDLE
  - pending flag = 0
- Input sync: uart_rx passes through a 2-flop synchronizer reset to 1. All RX decisions use the synchronized value rx_s.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.

RX FSM:
- RX_IDLE: on rx_s=0, clear counter and go to RX_START.
- RX_START: count to DELAY_FRAMES/2 (mid start bit), then sample.
  - rx_s still 0: go to RX_DATA, bit index 0, counter reset.
  - rx_s is 1: glitch; return to RX_IDLE.
- RX_DATA: every DELAY_FRAMES cycles, sample rx_s into data[bit_index], then increment bit_index. After bit 7, go to RX_STOP.
- RX_STOP: after DELAY_FRAMES cycles (mid stop bit), sample.
  - rx_s=1: good byte. In that same clock, latch led <= ~data[5:0] and raise a 1-cycle rx_valid. Return to RX_IDLE.
  - rx_s=0: framing error. Discard the byte; led unchanged; no echo. Go to RX_WAIT.
- RX_WAIT: stay until rx_s=1, then go to RX_IDLE.
- A byte whose start bit begins right after the mid-stop sample is received normally (back-to-back frames).

Echo / TX:
- Single-entry holding register tx_buf with a pending flag.
- On rx_valid: tx_buf <= byte and pending <= 1. If a byte is already pending, it is overwritten; newest wins.
- TX_IDLE: if pending, load the shift register, clear pending, go to TX_START.
  - A byte arriving while TX is idle starts its start bit within 2 cycles of rx_valid.
- TX_START: drive 0 for DELAY_FRAMES cycles.
- TX_DATA: drive 8 bits LSB first, each for DELAY_FRAMES cycles.
- TX_STOP: drive 1 for DELAY_FRAMES cycles, then return to TX_IDLE.
- rx_valid and TX load in the same cycle: the pending write happens; TX picks it up on a later IDLE cycle.
- uart_tx is a registered output.

Reset mid-operation:
- Any btn=0 immediately aborts RX and TX frames.
- uart_tx goes high asynchronously; led returns to all-off.
- After release, RX waits for a fresh falling edge.

Test Plan:
- Reset: btn=0 -> led=6'b111111, uart_tx=1. btn=1 with line idle -> outputs unchanged for 1000 cycles.
- Single byte, DELAY_FRAMES=8, 2 ns clock, bits 16 ns wide:
  - Stimulus: start at t=10, data bits 1,0,0,0,0,1,1,0 (byte 0x61), then stop bit.
  - Required: led stays 6'b111111 until the mid-stop sample (~t=170), then becomes 6'b011110.
  - Required: uart_tx then emits 0, 1,0,0,0,0,1,1,0, 1 with each bit 8 cycles wide.
- Glitch: uart_rx low for 2 cycles only -> no led change and no TX activity.
- Framing error: byte 0x3F sent with stop bit = 0 -> led unchanged, no echo. After the line returns high, a valid 0x05 gives led=6'b111010 and 0x05 is echoed.
- Back-to-back: 0x12 then 0x34 with no idle gap:
  - led=6'b101101 after the first byte, then 6'b001011 after the second.
  - uart_tx echoes both in order with no lost byte, because TX finishes 0x12 before the next load.
- Async reset mid-frame: btn=0 during TX data bit 3 -> uart_tx=1 and led=6'b111111 immediately. After btn=1, a new byte 0x61 is received and echoed correctly.
